uart_rx_oversample: RTL and testbench
=====================================

# uart_rx_oversample

Parametrised UART receiver, successor to the fixed 8N1 receiver. It samples the serial line on an external oversampling tick and validates the start bit at mid-bit. It supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits, and reports parity and framing errors alongside each received word. It sits between the pad-side RX line and the byte consumer, and is driven by the shared baud/oversample tick generator.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5–9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked: 1 or 2.
- OVERSAMPLE, 16, i_tick pulses per bit period; even, ≥ 4.
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_srx  input  1  raw serial line; idle high; asynchronous to i_clk.
- i_tick  input  1  single-cycle oversample strobe, OVERSAMPLE per bit period.
- o_rx_valid  output  1  one-cycle pulse when a frame completes.
- o_rx_data  output  DATA_BITS  received word, LSB first on the line; held until the next o_rx_valid.
- o_parity_err  output  1  parity mismatch for the current word; qualified by o_rx_valid.
- o_frame_err  output  1  stop bit sampled low; qualified by o_rx_valid.
- o_busy  output  1  high from start-bit detection until return to IDLE.

## Operation
- i_srx passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rxs`.
- tick_cnt (clog2(OVERSAMPLE) bits) and bit_cnt (clog2(DATA_BITS) bits) advance only on i_tick.
- FSM states and transitions:
  - IDLE: on i_tick with rxs==0, go to START; tick_cnt=0.
  - START: at tick_cnt==OVERSAMPLE/2-1, re-check rxs. If 0, go to DATA with tick_cnt=0 and bit_cnt=0. If 1, treat it as a glitch and return to IDLE.
  - DATA: at tick_cnt==OVERSAMPLE-1, sample rxs into shift register MSB and shift right. After DATA_BITS samples, go to PARITY if PARITY!=0, else STOP.
  - PARITY: sample rxs at mid-bit. The error bit is the XOR of all data bits ^ the sampled bit, inverted for odd parity.
  - STOP: sample at mid-bit for each stop bit. Any low sample sets frame_err. After the last stop bit, go to DONE.
  - DONE: one cycle. Drive o_rx_valid=1, load o_rx_data, o_parity_err and o_frame_err. Go to IDLE if frame_err==0, else to BREAK.
  - BREAK: wait until rxs==1 on an i_tick, then go to IDLE. This prevents a held-low line from retriggering.
- o_rx_data, o_parity_err and o_frame_err are registered on the DONE cycle only and are stable between valids.
- o_parity_err is always 0 when PARITY==0.
- The error flags never suppress o_rx_valid. Data is delivered with flags; the consumer decides what to do with it.
- Illegal state encodings go to IDLE.

## Timing
- Reset values: o_rx_valid=0, o_rx_data=0, o_parity_err=0, o_frame_err=0, o_busy=0, FSM=IDLE, synchronizer=1.
- Reset asserted mid-frame aborts immediately. No o_rx_valid is produced for the aborted frame.
- Synchronizer latency is 2 i_clk cycles.
- Each sample point is OVERSAMPLE/2 ticks after the detected falling edge, then every OVERSAMPLE ticks, ±1 tick of detection jitter.
- o_rx_valid rises in the i_clk cycle after the i_tick that samples the last stop bit. It lasts exactly 1 cycle.
- o_busy falls in the same cycle the FSM enters IDLE.
- Back-to-back frames: a start edge seen on the first i_tick after DONE is accepted. There is no dead time beyond one tick.
- i_tick asserted on consecutive clocks is legal: one tick per clock.

## Structure
- Package uart_pkg holds:
  - parity localparams: PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - the rx state enum: IDLE, START, DATA, PARITY, STOP, DONE, BREAK;
  - a shared `is_legal_cfg` check used in an elaboration-time assertion.
- One sub-module: uart_sync2, a 2-flop synchronizer with reset value parameter. It will be reused by the TX/CTS path.

## Test plan
- 8N1 at OVERSAMPLE=16: send 0xA5 → one o_rx_valid, o_rx_data=0xA5, both error flags 0, o_busy low after DONE.
- Low glitch on i_srx lasting 5 ticks, then idle → FSM returns to IDLE from START; no o_rx_valid.
- DATA_BITS=7, PARITY=2: send 0x55 with parity bit 1 (wrong) → o_rx_data=0x55, o_parity_err=1. Same word with parity bit 0 → o_parity_err=0.
- STOP_BITS=2: second stop bit driven low, then line held low for 3 bit times → o_rx_valid with o_frame_err=1 and no further valid until the line returns high.
- Assert i_rst_n low during DATA bit 4 of a 0x3C frame → all outputs return to reset values asynchronously; no valid. The next full frame, 0x81, is received correctly.
- Two back-to-back 8N1 frames, 0x00 then 0xFF, with no idle gap → two valids exactly 10 bit periods apart, with correct data and no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive (and future transmit) path.
//   PAR_NONE / PAR_ODD / PAR_EVEN : parity mode encodings for the PARITY parameter
//   rx_state_e                    : receiver FSM states
//   is_legal_cfg()                : parameter sanity check used at elaboration
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // States carry an RX_ prefix so they cannot collide with the PARITY
  // parameter of the modules that import this package.
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_DONE   = 3'd5,
    RX_BREAK  = 3'd6
  } rx_state_e;

  function automatic bit is_legal_cfg(input int data_bits, input int parity,
                                      input int stop_bits, input int oversample);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (oversample >= 4) && ((oversample % 2) == 0);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2
// Two-flop synchronizer for a single asynchronous input.
//   RESET_VAL : value both flops take during reset (1 for an idle-high line)
//   i_clk     : destination clock
//   i_rst_n   : asynchronous active-low reset
//   i_d       : asynchronous input
//   o_q       : synchronized output, two i_clk cycles of latency
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
// Oversampling UART receiver: DATA_BITS data bits (LSB first), optional
// odd/even parity, STOP_BITS stop bits. Bit timing comes from i_tick, which
// pulses OVERSAMPLE times per bit period.
//   i_clk        : system clock
//   i_rst_n      : asynchronous active-low reset
//   i_srx        : raw serial line, idle high, asynchronous to i_clk
//   i_tick       : single-cycle oversample strobe
//   o_rx_valid   : one-cycle pulse when a frame completes
//   o_rx_data    : received word, held until the next o_rx_valid
//   o_parity_err : parity mismatch for the word, qualified by o_rx_valid
//   o_frame_err  : a stop bit was sampled low, qualified by o_rx_valid
//   o_busy       : high from start-bit detection until the FSM is back in idle
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_srx,
  input  logic                 i_tick,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_HALF  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP  = BW'(STOP_BITS - 1);
  localparam logic          HAS_PARITY = (PARITY != PAR_NONE);
  localparam logic          ODD_INV    = (PARITY == PAR_ODD);

  if (!is_legal_cfg(DATA_BITS, PARITY, STOP_BITS, OVERSAMPLE)) begin : g_bad_cfg
    $error("uart_rx_oversample: illegal DATA_BITS/PARITY/STOP_BITS/OVERSAMPLE combination");
  end

  logic rxs;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_srx),
    .o_q    (rxs)
  );

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 out_perr_q, out_perr_d;
  logic                 out_ferr_q, out_ferr_d;
  logic                 busy_q, busy_d;

  // Next-state logic. After the start bit is confirmed at mid-bit, every
  // later sample lands a full bit period (OVERSAMPLE ticks) further on, so
  // all of them fall near the middle of their bit.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    out_perr_d  = out_perr_q;
    out_ferr_d  = out_ferr_q;

    case (state_q)
      RX_IDLE: begin
        if (i_tick && !rxs) begin
          state_d    = RX_START;
          tick_cnt_d = '0;
        end
      end

      RX_START: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_HALF) begin
            // A line that is high again at mid-bit was only a glitch.
            if (!rxs) begin
              state_d     = RX_DATA;
              tick_cnt_d  = '0;
              bit_cnt_d   = '0;
              par_err_d   = 1'b0;
              frame_err_d = 1'b0;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      RX_DATA: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_FULL) begin
            tick_cnt_d = '0;
            // LSB arrives first, so shifting right leaves it in bit 0.
            shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_d = '0;
              state_d   = HAS_PARITY ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      RX_PARITY: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_FULL) begin
            tick_cnt_d = '0;
            par_err_d  = (^shreg_q) ^ rxs ^ ODD_INV;
            state_d    = RX_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      RX_STOP: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_FULL) begin
            tick_cnt_d = '0;
            if (!rxs) begin
              frame_err_d = 1'b1;
            end
            // Outputs are loaded on entry to DONE so that valid and its
            // flags appear in the cycle right after the last stop sample.
            if (bit_cnt_q == LAST_STOP) begin
              state_d    = RX_DONE;
              rx_valid_d = 1'b1;
              rx_data_d  = shreg_q;
              out_perr_d = par_err_q & HAS_PARITY;
              out_ferr_d = frame_err_q | ~rxs;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      RX_DONE: begin
        // A framing error may mean the line is being held low (break);
        // wait for it to go high so it cannot look like a new start bit.
        state_d = frame_err_q ? RX_BREAK : RX_IDLE;
      end

      RX_BREAK: begin
        if (i_tick && rxs) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Busy is registered from the next state so it drops on the same edge
  // that returns the FSM to idle.
  always_comb begin
    busy_d = (state_d != RX_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= RX_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      out_perr_q  <= 1'b0;
      out_ferr_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      out_perr_q  <= out_perr_d;
      out_ferr_q  <= out_ferr_d;
      busy_q      <= busy_d;
    end
  end

  assign o_rx_valid   = rx_valid_q;
  assign o_rx_data    = rx_data_q;
  assign o_parity_err = out_perr_q;
  assign o_frame_err  = out_ferr_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample
// Drives three receiver configurations (8N1/16x, 7E1/16x, 8O2/8x) with
// serial frames built from the word, parity mode and stop bits, and compares
// the delivered words and flags against values computed from the frame.
module tb_uart_rx_oversample;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic tick  = 1'b0;
  logic srx [3];

  int     total = 0;
  int     bad   = 0;
  int     tick_count = 0;
  longint cyc = 0;
  int     tick_div = 3;
  int     div_cnt  = 0;

  logic       va, pa, fa, ba;
  logic [7:0] da;
  logic       vb, pb, fb, bb;
  logic [6:0] db;
  logic       vc, pc, fc, bc;
  logic [7:0] dc;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         tk;
    longint     cy;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];
  rec_t qc[$];

  uart_rx_oversample #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_srx(srx[0]), .i_tick(tick),
    .o_rx_valid(va), .o_rx_data(da), .o_parity_err(pa), .o_frame_err(fa), .o_busy(ba));

  uart_rx_oversample #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_srx(srx[1]), .i_tick(tick),
    .o_rx_valid(vb), .o_rx_data(db), .o_parity_err(pb), .o_frame_err(fb), .o_busy(bb));

  uart_rx_oversample #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(8)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_srx(srx[2]), .i_tick(tick),
    .o_rx_valid(vc), .o_rx_data(dc), .o_parity_err(pc), .o_frame_err(fc), .o_busy(bc));

  always #5 clk = ~clk;

  // Tick generator: one tick every tick_div clocks, counted at the edge it is seen.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (tick) tick_count++;
      #1;
      div_cnt = (div_cnt + 1 >= tick_div) ? 0 : div_cnt + 1;
      tick = (div_cnt == 0);
    end
  end

  // Record every delivered word with the tick and cycle it appeared in.
  always @(negedge clk) begin
    if (va === 1'b1) qa.push_back('{data: {1'b0, da}, perr: pa, ferr: fa, tk: tick_count, cy: cyc});
    if (vb === 1'b1) qb.push_back('{data: {2'b00, db}, perr: pb, ferr: fb, tk: tick_count, cy: cyc});
    if (vc === 1'b1) qc.push_back('{data: {1'b0, dc}, perr: pc, ferr: fc, tk: tick_count, cy: cyc});
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Returns 2ns after the next tick edge, when line changes are safe.
  task automatic wait_tick();
    @(tick_count);
    #2;
  endtask

  function automatic bit good_parity(input logic [8:0] w, input int nbits, input int mode);
    int ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(w[i]);
    return (mode == 2) ? bit'(ones % 2) : bit'(1 - (ones % 2));
  endfunction

  // Drives one full frame, starting right after the current tick.
  task automatic send_frame(input int line, input int os, input int nbits, input logic [8:0] word,
                            input int pmode, input bit pbit, input int nstop, input logic [1:0] stopv,
                            output int k0);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(word[i]);
    if (pmode != 0) bits.push_back(pbit);
    for (int i = 0; i < nstop; i++) bits.push_back(stopv[i]);
    k0 = tick_count;
    foreach (bits[j]) begin
      srx[line] = bits[j];
      repeat (os) wait_tick();
    end
  endtask

  task automatic idle_line(input int line, input int nticks);
    srx[line] = 1'b1;
    repeat (nticks) wait_tick();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    total++; if (va !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0b want 0", va); end
    total++; if (da !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %0h want 0", da); end
    total++; if (pa !== 1'b0) begin bad++; $display("[TB] FAIL reset_perr: got %0b want 0", pa); end
    total++; if (fa !== 1'b0) begin bad++; $display("[TB] FAIL reset_ferr: got %0b want 0", fa); end
    total++; if (ba !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b want 0", ba); end
    total++; if ({vb, db, pb, fb, bb} !== 11'd0) begin bad++; $display("[TB] FAIL reset_b: got %0h want 0", {vb, db, pb, fb, bb}); end
    total++; if ({vc, dc, pc, fc, bc} !== 12'd0) begin bad++; $display("[TB] FAIL reset_c: got %0h want 0", {vc, dc, pc, fc, bc}); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_basic_8n1();
    int k0;
    logic [8:0] w;
    $display("[TB] basic 8N1");
    wait_tick();
    for (int n = 0; n < 6; n++) begin
      w = (n == 0) ? 9'h0A5 : 9'($urandom_range(0, 255));
      qa.delete();
      send_frame(0, 16, 8, w, 0, 1'b0, 1, 2'b11, k0);
      total++; if (ba !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy: got %0b want 0", ba); end
      total++; if (qa.size() != 1) begin bad++; $display("[TB] FAIL basic_count: got %0d want 1", qa.size()); end
      if (qa.size() >= 1) begin
        total++; if (qa[0].data !== w) begin bad++; $display("[TB] FAIL basic_data: got %0h want %0h", qa[0].data, w); end
        total++; if ({qa[0].perr, qa[0].ferr} !== 2'b00) begin bad++; $display("[TB] FAIL basic_flags: got %0b want 00", {qa[0].perr, qa[0].ferr}); end
        // Detected one tick after the edge, last stop sampled at mid-bit of bit 9.
        total++; if (qa[0].tk != k0 + 1 + 8 + 16 * 9) begin bad++; $display("[TB] FAIL basic_latency: got %0d want %0d", qa[0].tk, k0 + 1 + 8 + 16 * 9); end
      end
      idle_line(0, 16);
    end
  endtask

  task automatic test_glitch();
    $display("[TB] start glitch");
    for (int r = 0; r < 4; r++) begin
      int len;
      len = (r == 0) ? 5 : int'($urandom_range(1, 6));
      qa.delete();
      srx[0] = 1'b0;
      for (int t = 1; t <= 40; t++) begin
        wait_tick();
        if (t == len) srx[0] = 1'b1;
        if (t == 3) begin
          total++; if (ba !== 1'b1) begin bad++; $display("[TB] FAIL glitch_busy_high: got %0b want 1", ba); end
        end
      end
      total++; if (qa.size() != 0) begin bad++; $display("[TB] FAIL glitch_no_valid: got %0d want 0", qa.size()); end
      total++; if (ba !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy_low: got %0b want 0", ba); end
    end
  endtask

  task automatic test_parity();
    int k0;
    logic [8:0] w;
    bit pbit;
    bit exp_perr;
    $display("[TB] 7E1 parity");
    wait_tick();
    for (int n = 0; n < 8; n++) begin
      w    = (n < 2) ? 9'h055 : 9'($urandom_range(0, 127));
      pbit = (n == 0) ? 1'b1 : (n == 1) ? 1'b0 : bit'($urandom_range(0, 1));
      exp_perr = (pbit != good_parity(w, 7, 2));
      qb.delete();
      send_frame(1, 16, 7, w, 2, pbit, 1, 2'b11, k0);
      total++; if (qb.size() != 1) begin bad++; $display("[TB] FAIL parity_count: got %0d want 1", qb.size()); end
      if (qb.size() >= 1) begin
        total++; if (qb[0].data !== w) begin bad++; $display("[TB] FAIL parity_data: got %0h want %0h", qb[0].data, w); end
        total++; if (qb[0].perr !== exp_perr) begin bad++; $display("[TB] FAIL parity_err: got %0b want %0b", qb[0].perr, exp_perr); end
        total++; if (qb[0].ferr !== 1'b0) begin bad++; $display("[TB] FAIL parity_ferr: got %0b want 0", qb[0].ferr); end
      end
      idle_line(1, 16);
    end
  endtask

  task automatic test_frame_break();
    int k0;
    logic [8:0] w;
    logic [1:0] sv;
    bit pbit;
    $display("[TB] 8O2 framing and break");
    wait_tick();
    w = 9'($urandom_range(0, 255));
    qc.delete();
    send_frame(2, 8, 8, w, 1, good_parity(w, 8, 1), 2, 2'b01, k0);
    srx[2] = 1'b0;
    repeat (24) wait_tick();
    total++; if (qc.size() != 1) begin bad++; $display("[TB] FAIL break_count: got %0d want 1", qc.size()); end
    if (qc.size() >= 1) begin
      total++; if (qc[0].data !== w) begin bad++; $display("[TB] FAIL break_data: got %0h want %0h", qc[0].data, w); end
      total++; if ({qc[0].perr, qc[0].ferr} !== 2'b01) begin bad++; $display("[TB] FAIL break_flags: got %0b want 01", {qc[0].perr, qc[0].ferr}); end
    end
    total++; if (bc !== 1'b1) begin bad++; $display("[TB] FAIL break_busy: got %0b want 1", bc); end
    idle_line(2, 16);
    total++; if (qc.size() != 1) begin bad++; $display("[TB] FAIL break_release_count: got %0d want 1", qc.size()); end
    total++; if (bc !== 1'b0) begin bad++; $display("[TB] FAIL break_release_busy: got %0b want 0", bc); end
    for (int n = 0; n < 6; n++) begin
      w    = 9'($urandom_range(0, 255));
      sv   = 2'($urandom_range(0, 3));
      pbit = bit'($urandom_range(0, 1));
      qc.delete();
      send_frame(2, 8, 8, w, 1, pbit, 2, sv, k0);
      idle_line(2, 16);
      total++; if (qc.size() != 1) begin bad++; $display("[TB] FAIL frame_count: got %0d want 1", qc.size()); end
      if (qc.size() >= 1) begin
        total++; if (qc[0].data !== w) begin bad++; $display("[TB] FAIL frame_data: got %0h want %0h", qc[0].data, w); end
        total++; if (qc[0].perr !== (pbit != good_parity(w, 8, 1))) begin bad++; $display("[TB] FAIL frame_perr: got %0b want %0b", qc[0].perr, (pbit != good_parity(w, 8, 1))); end
        total++; if (qc[0].ferr !== (sv != 2'b11)) begin bad++; $display("[TB] FAIL frame_ferr: got %0b want %0b", qc[0].ferr, (sv != 2'b11)); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int k0;
    logic [8:0] w;
    $display("[TB] reset during data bit 4");
    w = 9'h03C;
    qa.delete();
    wait_tick();
    srx[0] = 1'b0;
    repeat (16) wait_tick();
    for (int j = 0; j <= 4; j++) begin
      srx[0] = w[j];
      repeat ((j < 4) ? 16 : 4) wait_tick();
    end
    total++; if (ba !== 1'b1) begin bad++; $display("[TB] FAIL midframe_busy: got %0b want 1", ba); end
    #3 rst_n = 1'b0;
    #1;
    total++; if ({va, da, pa, fa, ba} !== 12'd0) begin bad++; $display("[TB] FAIL midframe_async_reset: got %0h want 0", {va, da, pa, fa, ba}); end
    srx[0] = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (40) wait_tick();
    total++; if (qa.size() != 0) begin bad++; $display("[TB] FAIL midframe_no_valid: got %0d want 0", qa.size()); end
    w = 9'h081;
    send_frame(0, 16, 8, w, 0, 1'b0, 1, 2'b11, k0);
    idle_line(0, 16);
    total++; if (qa.size() != 1) begin bad++; $display("[TB] FAIL after_reset_count: got %0d want 1", qa.size()); end
    if (qa.size() >= 1) begin
      total++; if (qa[0].data !== w) begin bad++; $display("[TB] FAIL after_reset_data: got %0h want %0h", qa[0].data, w); end
      total++; if ({qa[0].perr, qa[0].ferr} !== 2'b00) begin bad++; $display("[TB] FAIL after_reset_flags: got %0b want 00", {qa[0].perr, qa[0].ferr}); end
    end
  endtask

  task automatic test_back_to_back();
    int k0;
    logic [8:0] words[4];
    $display("[TB] back-to-back frames");
    qa.delete();
    wait_tick();
    send_frame(0, 16, 8, 9'h000, 0, 1'b0, 1, 2'b11, k0);
    send_frame(0, 16, 8, 9'h0FF, 0, 1'b0, 1, 2'b11, k0);
    idle_line(0, 32);
    total++; if (qa.size() != 2) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 2", qa.size()); end
    if (qa.size() >= 2) begin
      total++; if ({qa[0].data, qa[1].data} !== {9'h000, 9'h0FF}) begin bad++; $display("[TB] FAIL b2b_data: got %0h %0h want 0 ff", qa[0].data, qa[1].data); end
      total++; if ({qa[0].perr, qa[0].ferr, qa[1].perr, qa[1].ferr} !== 4'b0000) begin bad++; $display("[TB] FAIL b2b_flags: got %0b want 0000", {qa[0].perr, qa[0].ferr, qa[1].perr, qa[1].ferr}); end
      total++; if (qa[1].cy - qa[0].cy != 64'd480) begin bad++; $display("[TB] FAIL b2b_spacing: got %0d want 480", qa[1].cy - qa[0].cy); end
    end
    // Same again with a tick on every clock.
    tick_div = 1;
    repeat (8) wait_tick();
    qa.delete();
    foreach (words[i]) words[i] = 9'($urandom_range(0, 255));
    foreach (words[i]) send_frame(0, 16, 8, words[i], 0, 1'b0, 1, 2'b11, k0);
    idle_line(0, 32);
    total++; if (qa.size() != 4) begin bad++; $display("[TB] FAIL fast_count: got %0d want 4", qa.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < qa.size()) begin
        total++; if (qa[i].data !== words[i]) begin bad++; $display("[TB] FAIL fast_data: got %0h want %0h", qa[i].data, words[i]); end
        if (i > 0) begin
          total++; if (qa[i].tk - qa[i-1].tk != 160) begin bad++; $display("[TB] FAIL fast_spacing: got %0d want 160", qa[i].tk - qa[i-1].tk); end
        end
      end
    end
    tick_div = 3;
    repeat (4) wait_tick();
  endtask

  initial begin
    srx[0] = 1'b1;
    srx[1] = 1'b1;
    srx[2] = 1'b1;
    test_reset();
    test_basic_8n1();
    test_glitch();
    test_parity();
    test_frame_break();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
